// File: rtl/bram_rmw_ctrl_if.sv
// Bundle between the accumulate logic, the RMW controller and the
// dual-port membrane-potential BRAM. The controller takes the slave view.
interface bram_rmw_ctrl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) ();
  logic                  req_valid;
  logic                  req_ready;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_delta;
  logic                  clear_start;
  logic                  clear_done;
  logic                  busy;
  logic                  upd_valid;
  logic [ADDR_WIDTH-1:0] upd_addr;
  logic [DATA_WIDTH-1:0] upd_data;
  logic                  en_a, we_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] data_in_a;
  logic [DATA_WIDTH-1:0] data_out_a;
  logic                  en_b, we_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] data_in_b;

  modport slave (
    input  req_valid, req_addr, req_delta, clear_start, data_out_a,
    output req_ready, clear_done, busy, upd_valid, upd_addr, upd_data,
           en_a, we_a, addr_a, data_in_a, en_b, we_b, addr_b, data_in_b
  );

  modport master (
    output req_valid, req_addr, req_delta, clear_start, data_out_a,
    input  req_ready, clear_done, busy, upd_valid, upd_addr, upd_data,
           en_a, we_a, addr_a, data_in_a, en_b, we_b, addr_b, data_in_b
  );
endinterface

// File: rtl/bram_rmw_ctrl.sv
// Pipelined read-modify-write controller: reads on port A, saturated
// write-back on port B, one update per cycle with same-address forwarding,
// plus a full-memory zero sweep.
module bram_rmw_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  bram_rmw_ctrl_if.slave   bus
);
  localparam int DW = DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;

  typedef enum logic [1:0] {RUN, DRAIN, CLEAR} state_t;

  state_t               state;
  logic                 s1_valid;
  logic                 s1_fwd;
  logic [AW-1:0]        s1_addr;
  logic [DW-1:0]        s1_delta;
  logic [AW-1:0]        clr_cnt;
  logic                 upd_valid_q;
  logic [AW-1:0]        upd_addr_q;
  logic [DW-1:0]        upd_data_q;
  logic                 clear_done_q;
  logic                 busy_q;

  logic                 xfer;
  logic                 fwd;
  logic [DW-1:0]        old_val;
  logic [DW:0]          sum;
  logic [DW-1:0]        new_val;

  assign bus.req_ready = (state == RUN);
  assign xfer          = bus.req_valid && bus.req_ready;
  // A back-to-back hit on the address being written this cycle takes the
  // value from the write path instead of reading port A.
  assign fwd           = s1_valid && (s1_addr == bus.req_addr);

  assign bus.en_a      = xfer && !fwd;
  assign bus.we_a      = 1'b0;
  assign bus.addr_a    = bus.req_addr;
  assign bus.data_in_a = '0;

  assign bus.upd_valid  = upd_valid_q;
  assign bus.upd_addr   = upd_addr_q;
  assign bus.upd_data   = upd_data_q;
  assign bus.clear_done = clear_done_q;
  assign bus.busy       = busy_q;

  // Stage-1 add with saturation; upd_data_q holds last cycle's write value.
  always_comb begin
    old_val = s1_fwd ? upd_data_q : bus.data_out_a;
    sum     = {old_val[DW-1], old_val} + {s1_delta[DW-1], s1_delta};
    new_val = sum[DW-1:0];
    if (sum[DW] != sum[DW-1])
      new_val = sum[DW] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
  end

  // Port B: sweep writes zeros, otherwise serves the stage-1 write-back.
  always_comb begin
    bus.en_b      = 1'b0;
    bus.we_b      = 1'b0;
    bus.addr_b    = s1_addr;
    bus.data_in_b = new_val;
    if (state == CLEAR) begin
      bus.en_b      = 1'b1;
      bus.we_b      = 1'b1;
      bus.addr_b    = clr_cnt;
      bus.data_in_b = '0;
    end else if (s1_valid) begin
      bus.en_b = 1'b1;
      bus.we_b = 1'b1;
    end
  end

  // Request pipeline and update response register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid    <= 1'b0;
      s1_fwd      <= 1'b0;
      s1_addr     <= '0;
      s1_delta    <= '0;
      upd_valid_q <= 1'b0;
      upd_addr_q  <= '0;
      upd_data_q  <= '0;
    end else begin
      s1_valid    <= xfer;
      if (xfer) begin
        s1_addr  <= bus.req_addr;
        s1_delta <= bus.req_delta;
        s1_fwd   <= fwd;
      end
      upd_valid_q <= s1_valid;
      if (s1_valid) begin
        upd_addr_q <= s1_addr;
        upd_data_q <= new_val;
      end
    end
  end

  // Control FSM: RUN -> DRAIN (flush stage 1) -> CLEAR (sweep) -> RUN.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= RUN;
      clr_cnt      <= '0;
      clear_done_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      clear_done_q <= 1'b0;
      case (state)
        RUN: begin
          if (bus.clear_start) begin
            state  <= DRAIN;
            busy_q <= 1'b1;
          end
        end
        DRAIN: begin
          state   <= CLEAR;
          clr_cnt <= '0;
        end
        CLEAR: begin
          clr_cnt <= clr_cnt + {{(AW-1){1'b0}}, 1'b1};
          if (clr_cnt == {AW{1'b1}}) begin
            state        <= RUN;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b1;
          end
        end
        default: state <= RUN;
      endcase
    end
  end
endmodule

// File: tb/tb_bram_rmw_ctrl.sv
// Directed plus randomized bench for bram_rmw_ctrl with a BRAM model and
// a sequential reference model of the memory contents.
module tb_bram_rmw_ctrl;
  localparam int W     = 16;
  localparam int A     = 4;
  localparam int DEPTH = 2 ** A;
  localparam int MAXV  = 2 ** (W - 1) - 1;
  localparam int MINV  = -(2 ** (W - 1));

  logic clk;
  logic rst_n;

  bram_rmw_ctrl_if #(.DATA_WIDTH(W), .ADDR_WIDTH(A)) bus ();

  bram_rmw_ctrl #(.DATA_WIDTH(W), .ADDR_WIDTH(A)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // BRAM model with 1-cycle registered read and a bench-only preload port
  logic [W-1:0] mem [DEPTH];
  logic [W-1:0] dout;
  logic         pre_en;
  logic [A-1:0] pre_addr;
  logic [W-1:0] pre_data;

  always @(posedge clk) begin
    if (pre_en) mem[pre_addr] <= pre_data;
    else if (bus.en_b && bus.we_b) mem[bus.addr_b] <= bus.data_in_b;
    if (bus.en_a) dout <= mem[bus.addr_a];
  end
  assign bus.data_out_a = dout;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int addr;
    int val;
    int cyc;
  } exp_t;

  exp_t exp_q[$];
  int   ref_mem [DEPTH];

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int sat(input int v);
    if (v > MAXV) return MAXV;
    if (v < MINV) return MINV;
    return v;
  endfunction

  // Response and collision monitor, mid-cycle
  always @(negedge clk) begin
    check("no_collision",
          {31'd0, !(bus.en_a && bus.en_b && bus.addr_a == bus.addr_b)}, 1);
    if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      check("upd_late", 0, 1);
      void'(exp_q.pop_front());
    end
    if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
      check("upd_valid", {31'd0, bus.upd_valid}, 1);
      check("upd_addr", {28'd0, bus.upd_addr}, exp_q[0].addr);
      check("upd_data", $signed(bus.upd_data), exp_q[0].val);
      void'(exp_q.pop_front());
    end else begin
      check("upd_idle", {31'd0, bus.upd_valid}, 0);
    end
  end

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      bus.req_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  // Present one request for one cycle; exp_en_a < 0 skips the port-A check
  task automatic send(input int a, input int d, input int exp_en_a);
    exp_t e;
    bus.req_valid = 1'b1;
    bus.req_addr  = A'(a);
    bus.req_delta = W'(d);
    #1;
    check("req_ready", {31'd0, bus.req_ready}, 1);
    if (exp_en_a >= 0) check("en_a", {31'd0, bus.en_a}, exp_en_a);
    ref_mem[a] = sat(ref_mem[a] + d);
    e.addr = a;
    e.val  = ref_mem[a];
    e.cyc  = cyc + 2;
    exp_q.push_back(e);
    @(negedge clk);
    bus.req_valid = 1'b0;
  endtask

  task automatic preload(input int a, input int v);
    pre_en   = 1'b1;
    pre_addr = A'(a);
    pre_data = W'(v);
    @(negedge clk);
    pre_en = 1'b0;
    ref_mem[a] = v;
  endtask

  task automatic check_mem(input string tag);
    for (int a = 0; a < DEPTH; a++)
      check(tag, $signed(mem[a]), ref_mem[a]);
  endtask

  // Clear sweep, optionally with a request accepted in the clear_start cycle
  task automatic run_clear(input bit with_req, input int a, input int d);
    exp_t e;
    int   wv;
    wv = 0;
    bus.clear_start = 1'b1;
    if (with_req) begin
      bus.req_valid = 1'b1;
      bus.req_addr  = A'(a);
      bus.req_delta = W'(d);
    end
    #1;
    check("clr_ready0", {31'd0, bus.req_ready}, 1);
    if (with_req) begin
      ref_mem[a] = sat(ref_mem[a] + d);
      wv     = ref_mem[a];
      e.addr = a;
      e.val  = wv;
      e.cyc  = cyc + 2;
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.clear_start = 1'b0;
    bus.req_valid   = 1'b0;
    for (int i = 1; i <= DEPTH + 3; i++) begin
      check("clr_busy", {31'd0, bus.busy}, (i <= DEPTH + 1) ? 1 : 0);
      check("clr_done", {31'd0, bus.clear_done}, (i == DEPTH + 2) ? 1 : 0);
      check("clr_ready", {31'd0, bus.req_ready}, (i >= DEPTH + 2) ? 1 : 0);
      if (i == 1) begin
        check("drain_en_b", {31'd0, bus.en_b}, with_req ? 1 : 0);
        if (with_req) begin
          check("drain_addr_b", {28'd0, bus.addr_b}, a);
          check("drain_data_b", $signed(bus.data_in_b), wv);
        end
      end
      if (i >= 2 && i <= DEPTH + 1) begin
        check("sweep_we", {30'd0, bus.en_b, bus.we_b}, 3);
        check("sweep_addr", {28'd0, bus.addr_b}, i - 2);
        check("sweep_data", $signed(bus.data_in_b), 0);
      end
      @(negedge clk);
    end
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = 0;
    check_mem("clr_mem");
  endtask

  initial begin
    #100000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst_n           = 1'b0;
    bus.req_valid   = 1'b0;
    bus.req_addr    = '0;
    bus.req_delta   = '0;
    bus.clear_start = 1'b0;
    pre_en          = 1'b0;
    pre_addr        = '0;
    pre_data        = '0;
    for (int k = 0; k < DEPTH; k++) ref_mem[k] = 0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_upd_valid", {31'd0, bus.upd_valid}, 0);
    check("rst_clear_done", {31'd0, bus.clear_done}, 0);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_ports", {28'd0, bus.en_a, bus.we_a, bus.en_b, bus.we_b}, 0);
    check("rst_ready", {31'd0, bus.req_ready}, 1);
    rst_n = 1'b1;
    @(negedge clk);

    // Initial sweep establishes known contents
    run_clear(1'b0, 0, 0);

    // Single update: write on N+1, response on N+2
    send(3, 5, 1);
    check("wr_en_b", {30'd0, bus.en_b, bus.we_b}, 3);
    check("wr_addr_b", {28'd0, bus.addr_b}, 3);
    check("wr_data_b", $signed(bus.data_in_b), 5);
    idle(3);

    // Chained forwarding on one address
    send(7, 1, 1);
    send(7, 1, 0);
    send(7, 1, 0);
    send(7, 1, 0);
    idle(3);
    check("chain_mem7", $signed(mem[7]), 4);

    // Saturation both directions
    preload(2, 32760);
    send(2, 100, 1);
    idle(3);
    check("sat_hi", $signed(mem[2]), MAXV);
    preload(2, -32760);
    send(2, -100, 1);
    idle(3);
    check("sat_lo", $signed(mem[2]), MINV);

    // Interleaved: gap of one cycle reads the BRAM normally
    preload(1, 0);
    preload(2, 0);
    send(1, 2, 1);
    send(2, 3, 1);
    send(1, 4, 1);
    idle(3);
    check("ilv_mem1", $signed(mem[1]), 6);
    check("ilv_mem2", $signed(mem[2]), 3);

    // Request accepted together with clear_start completes in DRAIN
    run_clear(1'b1, 5, 9);

    // Randomized traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) begin
        int a;
        int d;
        a = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, DEPTH - 1))
                                        : int'($urandom_range(0, 2));
        if ($urandom_range(0, 4) == 0) d = int'($urandom_range(0, 60000)) - 30000;
        else d = int'($urandom_range(0, 100)) - 50;
        send(a, d, -1);
      end else begin
        idle(1);
      end
    end
    idle(4);
    check_mem("rand_mem");

    // Reset in the middle of a sweep
    for (int k = 0; k < DEPTH; k++) preload(k, 100 + k * 7);
    bus.clear_start = 1'b1;
    @(negedge clk);
    bus.clear_start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_addr_b", {28'd0, bus.addr_b}, 8);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", {31'd0, bus.busy}, 0);
    check("mid_rst_ports", {28'd0, bus.en_a, bus.we_a, bus.en_b, bus.we_b}, 0);
    check("mid_rst_done", {31'd0, bus.clear_done}, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_ready", {31'd0, bus.req_ready}, 1);
    for (int i = 0; i < DEPTH + 4; i++) begin
      @(negedge clk);
      check("mid_no_done", {31'd0, bus.clear_done}, 0);
    end
    for (int k = 0; k < 8; k++) ref_mem[k] = 0;
    check_mem("mid_mem");

    check("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/bram_rmw_ctrl.md
Name: bram_rmw_ctrl

Overview:
Initiator-side controller for a dual-port block RAM with 1-cycle registered read. It accepts a stream of (address, signed delta) update requests and performs a pipelined read-modify-write at one request per cycle. Reads use port A and saturated write-backs use port B. It forwards same-address back-to-back updates so that no port A/B collision is ever issued. It also provides a full-memory clear sweep. It sits between the convolution event/accumulate logic and the membrane-potential BRAM.

Parameters:
DATA_WIDTH, 16, word width; stored values and deltas are two's-complement signed.
ADDR_WIDTH, 10, address width; memory depth DEPTH = 2**ADDR_WIDTH.

Ports:
clk  in  1  single clock, rising edge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  update request valid
req_ready  out  1  controller can accept a request this cycle
req_addr  in  ADDR_WIDTH  target address
req_delta  in  DATA_WIDTH  signed increment
clear_start  in  1  single-cycle pulse requesting a zero sweep of the whole memory
clear_done  out  1  single-cycle pulse when the sweep completes
busy  out  1  high while draining or clearing
upd_valid  out  1  an update's write-back was issued last cycle
upd_addr  out  ADDR_WIDTH  address of that update
upd_data  out  DATA_WIDTH  new value written
en_a, we_a  out  1 each  BRAM port A enable and write enable (we_a is always 0)
addr_a  out  ADDR_WIDTH  port A address
data_in_a  out  DATA_WIDTH  tied to 0
data_out_a  in  DATA_WIDTH  port A read data, valid the cycle after en_a
en_b, we_b  out  1 each  BRAM port B enable and write enable
addr_b  out  ADDR_WIDTH  port B address
data_in_b  out  DATA_WIDTH  port B write data

Behaviour:
- Reset (async, rst_n=0):
  - state=RUN; stage-1 valid=0; clear counter=0.
  - All registered outputs (upd_*, clear_done, busy) = 0.
  - Port enables and write enables evaluate to 0.
- States:
  - RUN: normal operation.
  - DRAIN: exactly 1 cycle.
  - CLEAR: zero sweep.
- Transitions:
  - RUN -> DRAIN when clear_start=1.
  - DRAIN -> CLEAR unconditionally.
  - CLEAR -> RUN after address DEPTH-1 is written.
  - clear_start outside RUN is ignored.
- Handshake:
  - req_ready = (state==RUN), combinational.
  - Transfer occurs when req_valid && req_ready.
  - A request accepted in the same cycle as clear_start is still completed, during DRAIN.
- Stage 0 (accept cycle N):
  - fwd = stage-1 valid && stage-1 addr == req_addr.
  - If !fwd: en_a=1, addr_a=req_addr.
  - If fwd: en_a=0, so port A never reads an address port B is writing.
  - Register addr, delta and fwd into stage 1 (valid=1).
- Stage 1 (cycle N+1):
  - old = fwd ? (value written on port B in cycle N) : data_out_a.
  - new = sat(old + delta): compute in DATA_WIDTH+1 bits, then clamp to [-2^(W-1), 2^(W-1)-1].
  - Drive en_b=we_b=1, addr_b=stage-1 addr, data_in_b=new.
- Response (cycle N+2): upd_valid=1, with upd_addr and upd_data equal to the cycle N+1 write.
- Latency and throughput:
  - Accept to BRAM write: 1 cycle. Accept to upd_valid: 2 cycles.
  - Throughput: 1 request/cycle, including repeated identical addresses (chained forwarding).
- Non-adjacent same-address requests (gap >= 1 cycle) read the BRAM normally; the write has already landed.
- DRAIN:
  - Port B serves a pending stage-1 write if one exists.
  - No new read is issued; busy=1.
- CLEAR:
  - Each cycle: en_b=we_b=1, addr_b=counter, data_in_b=0; counter increments.
  - The counter is reset to 0 on entry.
  - After address DEPTH-1 is written: clear_done=1 for exactly one cycle (registered, the cycle after that write) and state returns to RUN.
  - busy=1 from the cycle after clear_start through the last CLEAR cycle.
  - upd_valid stays 0 for sweep writes.
- Reset mid-sweep: the sweep aborts immediately, no clear_done, memory is partially cleared. Reset mid-update: the in-flight write is dropped.
- Collision invariant: a cycle with en_a && en_b && addr_a==addr_b never occurs.

Test Plan:
- Params W=16, A=4. After clear, send (addr 3, +5) -> BRAM write 5 at cycle N+1; upd_valid at N+2 with addr 3, data 5.
- Back-to-back (7,+1) x4 on consecutive cycles -> en_a low for requests 2-4; writes 1,2,3,4; upd_data 1,2,3,4 in consecutive cycles; no collision warning.
- Preload addr 2 = 32760, send (2,+100) -> 32767. Preload -32760, send (2,-100) -> -32768 (saturation both directions).
- Interleaved (1,+2),(2,+3),(1,+4) at full rate -> addr 1 = 6 and addr 2 = 3; the third request reads the BRAM normally (no forward).
- Accept (5,+9) in the same cycle as clear_start -> req_ready low next cycle; DRAIN writes 9; sweep then writes 16 zeros; clear_done pulses once, 18 cycles after clear_start; memory all 0.
- Assert rst_n=0 at sweep address 8 -> outputs 0 immediately, no clear_done, addresses 8-15 keep old data, req_ready=1 after reset release.
